// File: rtl/rgb_fade_pwm.sv
// RGB LED fader: each channel ramps its brightness level up or down toward a 1-bit target
// and drives its pin with a PWM of period 2^PWM_BITS-1 cycles.
module rgb_fade_pwm #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned STEP_INTERVAL = 7812
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                red_in,
    input  logic                green_in,
    input  logic                blue_in,
    input  logic                enable,
    output logic                red_out,
    output logic                green_out,
    output logic                blue_out,
    output logic [PWM_BITS-1:0] red_level,
    output logic [PWM_BITS-1:0] green_level,
    output logic [PWM_BITS-1:0] blue_level,
    output logic                fading
);
    localparam int unsigned TimerW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [TimerW-1:0]   TimerLast = TimerW'(STEP_INTERVAL - 1);
    localparam logic [PWM_BITS-1:0] LevelMax  = '1;
    localparam logic [PWM_BITS-1:0] PwmLast   = {{(PWM_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {StLow, StRising, StHigh, StFalling} state_e;

    logic [2:0]          target_q;
    logic [2:0]          out_q;
    logic [TimerW-1:0]   timer_q;
    logic [PWM_BITS-1:0] pwm_q;
    state_e              state_q [3];
    state_e              state_d [3];
    logic [PWM_BITS-1:0] level_q [3];
    logic [PWM_BITS-1:0] level_d [3];
    logic                step_tick;

    assign step_tick = (timer_q == TimerLast);

    // Transition first, then step the level in the direction of the state just entered.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            unique case (state_q[i])
                StLow:     state_d[i] = target_q[i] ? StRising : StLow;
                StRising:  state_d[i] = target_q[i] ? StRising : StFalling;
                StHigh:    state_d[i] = target_q[i] ? StHigh   : StFalling;
                StFalling: state_d[i] = target_q[i] ? StRising : StFalling;
                default:   state_d[i] = StLow;
            endcase
            if (step_tick) begin
                if (state_d[i] == StRising && level_q[i] != LevelMax) begin
                    level_d[i] = level_q[i] + 1'b1;
                end else if (state_d[i] == StFalling && level_q[i] != '0) begin
                    level_d[i] = level_q[i] - 1'b1;
                end
            end
            if (state_d[i] == StRising && level_d[i] == LevelMax) begin
                state_d[i] = StHigh;
            end
            if (state_d[i] == StFalling && level_d[i] == '0) begin
                state_d[i] = StLow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
            out_q    <= '0;
            timer_q  <= '0;
            pwm_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StLow;
                level_q[i] <= '0;
            end
        end else begin
            target_q <= {blue_in, green_in, red_in};
            for (int i = 0; i < 3; i++) begin
                out_q[i] <= enable && (level_q[i] > pwm_q);
            end
            if (enable) begin
                timer_q <= step_tick ? '0 : timer_q + 1'b1;
                pwm_q   <= (pwm_q == PwmLast) ? '0 : pwm_q + 1'b1;
                for (int i = 0; i < 3; i++) begin
                    state_q[i] <= state_d[i];
                    level_q[i] <= level_d[i];
                end
            end
        end
    end

    always_comb begin
        fading = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (state_q[i] == StRising || state_q[i] == StFalling) begin
                fading = 1'b1;
            end
        end
    end

    assign red_out     = out_q[0];
    assign green_out   = out_q[1];
    assign blue_out    = out_q[2];
    assign red_level   = level_q[0];
    assign green_level = level_q[1];
    assign blue_level  = level_q[2];

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Scoreboard bench for rgb_fade_pwm: stimulus queues expected values, a negedge monitor
// pops and compares them.
module tb_rgb_fade_pwm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, red_in, green_in, blue_in;
    logic       red_out, green_out, blue_out, fading;
    logic [3:0] red_level, green_level, blue_level;

    logic       d_en, d_red, d_zero;
    logic       d_red_out, d_green_out, d_blue_out, d_fading;
    logic [3:0] d_red_level, d_green_level, d_blue_level;

    rgb_fade_pwm #(.PWM_BITS(4), .STEP_INTERVAL(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .enable     (enable),
        .red_out    (red_out),
        .green_out  (green_out),
        .blue_out   (blue_out),
        .red_level  (red_level),
        .green_level(green_level),
        .blue_level (blue_level),
        .fading     (fading)
    );

    // Slow-stepping copy so a level stays constant across whole PWM periods.
    rgb_fade_pwm #(.PWM_BITS(4), .STEP_INTERVAL(64)) u_duty (
        .clk        (clk),
        .rst        (rst),
        .red_in     (d_red),
        .green_in   (d_zero),
        .blue_in    (d_zero),
        .enable     (d_en),
        .red_out    (d_red_out),
        .green_out  (d_green_out),
        .blue_out   (d_blue_out),
        .red_level  (d_red_level),
        .green_level(d_green_level),
        .blue_level (d_blue_level),
        .fading     (d_fading)
    );

    typedef enum int {SRedL, SGrnL, SBluL, SRedO, SGrnO, SBluO, SFade, SDuty, SDLvl, SDOut} sel_e;
    typedef struct {
        int    cyc;
        sel_e  sel;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   duty_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(sel_e s);
        case (s)
            SRedL:   return int'(red_level);
            SGrnL:   return int'(green_level);
            SBluL:   return int'(blue_level);
            SRedO:   return int'(red_out);
            SGrnO:   return int'(green_out);
            SBluO:   return int'(blue_out);
            SFade:   return int'(fading);
            SDuty:   return duty_hi;
            SDLvl:   return int'(d_red_level);
            SDOut:   return int'(d_red_out);
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (actual(e.sel) != e.val) begin
                errors++;
                $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                         e.name, cyc, actual(e.sel), e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input sel_e s, input int v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = s;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        red_in   = 1'b0;
        green_in = 1'b0;
        blue_in  = 1'b0;
        step(2);
    endtask

    initial begin : timeout
        #100000;
        $display("FAIL timeout: simulation did not complete, got hang, expected finish");
        $fatal(1);
    end

    initial begin : stim
        enable = 1'b1;
        d_en   = 1'b1;
        d_red  = 1'b0;
        d_zero = 1'b0;
        do_reset();
        expect_v(SRedL, 0, "reset_red_level");
        expect_v(SGrnL, 0, "reset_green_level");
        expect_v(SBluL, 0, "reset_blue_level");
        expect_v(SRedO, 0, "reset_red_out");
        expect_v(SGrnO, 0, "reset_green_out");
        expect_v(SBluO, 0, "reset_blue_out");
        expect_v(SFade, 0, "reset_fading");
        expect_v(SDLvl, 0, "reset_duty_level");

        // Duty: level 5 reached at edge 320 of the slow copy.
        rst   = 1'b0;
        d_red = 1'b1;
        step(330);
        expect_v(SDLvl, 5, "duty_level_ramp");
        duty_hi = 0;
        repeat (15) begin
            step(1);
            if (d_red_out) duty_hi++;
        end
        expect_v(SDuty, 5, "duty_high_cycles");
        expect_v(SDLvl, 5, "duty_level_steady");
        d_en = 1'b0;
        step(1);
        expect_v(SDOut, 0, "duty_dark_first");
        repeat (20) begin
            step(1);
            expect_v(SDOut, 0, "duty_dark");
        end
        expect_v(SDLvl, 5, "duty_level_held");
        d_en    = 1'b1;
        duty_hi = 0;
        repeat (15) begin
            step(1);
            if (d_red_out) duty_hi++;
        end
        expect_v(SDuty, 5, "duty_resume_high_cycles");
        expect_v(SDLvl, 5, "duty_resume_level");
        d_red = 1'b0;

        // Full rise: level k at edge 4k after release.
        do_reset();
        rst    = 1'b0;
        red_in = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step(3);
            expect_v(SRedL, k - 1, "rise_level_pre");
            if (k == 1 || k == 15) expect_v(SFade, 1, "rise_fading");
            step(1);
            expect_v(SRedL, k, "rise_level_tick");
            expect_v(SGrnL, 0, "rise_green_idle");
            expect_v(SBluL, 0, "rise_blue_idle");
        end
        expect_v(SFade, 0, "rise_done_fading");
        repeat (15) begin
            step(1);
            expect_v(SRedO, 1, "red_full_on");
            expect_v(SGrnO, 0, "green_dark");
            expect_v(SRedL, 15, "red_high_hold");
        end

        // Mid-ramp reversal at level 7.
        do_reset();
        rst    = 1'b0;
        red_in = 1'b1;
        step(28);
        expect_v(SRedL, 7, "rev_peak");
        red_in = 1'b0;
        step(2);
        expect_v(SRedL, 7, "rev_no_jump");
        expect_v(SFade, 1, "rev_fading");
        step(1);
        expect_v(SRedL, 7, "rev_hold");
        step(1);
        expect_v(SRedL, 6, "rev_first_down");
        for (int v = 5; v >= 0; v--) begin
            step(4);
            expect_v(SRedL, v, "rev_down");
        end
        expect_v(SFade, 0, "rev_low_fading");
        step(4);
        expect_v(SRedL, 0, "rev_low_level");
        expect_v(SRedO, 0, "rev_low_out");

        // Target change lands on a step_tick edge.
        do_reset();
        rst = 1'b0;
        step(2);
        green_in = 1'b1;
        step(1);
        expect_v(SGrnL, 0, "sim_before");
        expect_v(SFade, 0, "sim_before_fading");
        step(1);
        expect_v(SGrnL, 1, "sim_on_tick");
        expect_v(SFade, 1, "sim_fading");
        step(4);
        expect_v(SGrnL, 2, "sim_next");

        // Reset at blue level 9.
        do_reset();
        rst     = 1'b0;
        blue_in = 1'b1;
        step(36);
        expect_v(SBluL, 9, "rst_mid_level");
        rst = 1'b1;
        step(1);
        expect_v(SRedL, 0, "rst_mid_red");
        expect_v(SGrnL, 0, "rst_mid_green");
        expect_v(SBluL, 0, "rst_mid_blue");
        expect_v(SRedO, 0, "rst_mid_red_out");
        expect_v(SGrnO, 0, "rst_mid_green_out");
        expect_v(SBluO, 0, "rst_mid_blue_out");
        expect_v(SFade, 0, "rst_mid_fading");
        rst = 1'b0;
        step(3);
        expect_v(SBluL, 0, "restart_pre");
        expect_v(SFade, 1, "restart_fading");
        step(1);
        expect_v(SBluL, 1, "restart_first");
        step(4);
        expect_v(SBluL, 2, "restart_second");

        // Red and green in lockstep.
        do_reset();
        rst      = 1'b0;
        red_in   = 1'b1;
        green_in = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step(1);
            expect_v(SRedL, n / 4, "multi_red");
            expect_v(SGrnL, n / 4, "multi_green");
            expect_v(SBluL, 0, "multi_blue");
        end

        step(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
